clkdiv_bank: RTL and testbench



---
 rtl/clkdiv_bank.sv | 114 +++++++++++
 tb/tb_clkdiv_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_bank.sv
// Multi-channel programmable clock divider with shadowed half-periods and sync.
// Optional per-channel phase offset on sync when CLKDIV_PHASE_EN is defined.
module clkdiv_bank #(
    parameter int unsigned      CHANNELS   = 4,
    parameter int unsigned      CH_AW      = 2,
    parameter int unsigned      CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEFAULT_HP = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_AW-1:0]    cfg_ch,
    input  logic                cfg_reg,
    input  logic [CNT_W-1:0]    cfg_wdata,
    output logic [CNT_W-1:0]    cfg_rdata,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CNT_W-1:0]    hp_act_q [CHANNELS];
    logic [CNT_W-1:0]    hp_act_d [CHANNELS];
    logic [CNT_W-1:0]    hp_shd_q [CHANNELS];
    logic [CNT_W-1:0]    hp_shd_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
`ifdef CLKDIV_PHASE_EN
    logic [CNT_W-1:0]    ph_shd_q [CHANNELS];
    logic [CNT_W-1:0]    ph_shd_d [CHANNELS];
`endif

    always_comb begin
        cnt_d    = cnt_q;
        hp_act_d = hp_act_q;
        hp_shd_d = hp_shd_q;
        out_d    = out_q;
        tick_d   = '0;
`ifdef CLKDIV_PHASE_EN
        ph_shd_d = ph_shd_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && !cfg_reg && cfg_ch == CH_AW'(i))
                hp_shd_d[i] = cfg_wdata;
`ifdef CLKDIV_PHASE_EN
            if (cfg_we && cfg_reg && cfg_ch == CH_AW'(i))
                ph_shd_d[i] = cfg_wdata;
`endif
            // A same-cycle write is visible here, so it lands in hp_act at once.
            if (sync) begin
                hp_act_d[i] = hp_shd_d[i];
                out_d[i]    = 1'b0;
`ifdef CLKDIV_PHASE_EN
                cnt_d[i] = (ph_shd_d[i] < hp_shd_d[i]) ? ph_shd_d[i] : hp_shd_d[i];
`else
                cnt_d[i] = '0;
`endif
            end else if (en[i]) begin
                if (cnt_q[i] == hp_act_q[i]) begin
                    cnt_d[i]    = '0;
                    out_d[i]    = ~out_q[i];
                    tick_d[i]   = ~out_q[i];
                    hp_act_d[i] = hp_shd_d[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_AW'(i)) begin
                if (!cfg_reg)
                    cfg_rdata = hp_shd_q[i];
`ifdef CLKDIV_PHASE_EN
                else
                    cfg_rdata = ph_shd_q[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                hp_act_q[i] <= DEFAULT_HP;
                hp_shd_q[i] <= DEFAULT_HP;
`ifdef CLKDIV_PHASE_EN
                ph_shd_q[i] <= '0;
`endif
            end
            out_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            hp_act_q <= hp_act_d;
            hp_shd_q <= hp_shd_d;
`ifdef CLKDIV_PHASE_EN
            ph_shd_q <= ph_shd_d;
`endif
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed testbench for clkdiv_bank (4 channels, 3-bit channel select).
// Phase-offset scenario runs only when CLKDIV_PHASE_EN is defined.
module tb_clkdiv_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        sync;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic        cfg_reg;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int errors = 0;
    int checks = 0;

    clkdiv_bank #(
        .CHANNELS(4), .CH_AW(3), .CNT_W(32), .DEFAULT_HP(32'd0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reg(cfg_reg),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ch, input logic r, input logic [31:0] d);
        cfg_ch = ch; cfg_reg = r; cfg_wdata = d; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 4'h0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = 3'd0; cfg_reg = 1'b0; cfg_wdata = '0;
        step(); step();
        checks++;
        if (clk_out !== 4'h0) begin errors++;
            $display("FAIL reset_clk_out got %h exp 0", clk_out); end
        checks++;
        if (tick !== 4'h0) begin errors++;
            $display("FAIL reset_tick got %h exp 0", tick); end
        checks++;
        if (cfg_rdata !== 32'd0) begin errors++;
            $display("FAIL reset_rdata got %h exp 0", cfg_rdata); end
        rst = 1'b0; en = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] e;
            step();
            e = (k % 2 == 1) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== e) begin errors++;
                $display("FAIL div2_out k=%0d got %h exp %h", k, clk_out, e); end
            checks++;
            if (tick !== e) begin errors++;
                $display("FAIL div2_tick k=%0d got %h exp %h", k, tick, e); end
        end
    endtask

    task automatic test_hp8();
        wr(3'd1, 1'b0, 32'd8);
        checks++;
        if (cfg_rdata !== 32'd8) begin errors++;
            $display("FAIL hp8_rdata got %0d exp 8", cfg_rdata); end
        pulse_sync();
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin errors++;
            $display("FAIL sync_clear got %h/%h exp 0/0", clk_out, tick); end
        for (int k = 1; k <= 36; k++) begin
            logic eo, et;
            step();
            eo = (k < 9) ? 1'b0 : ((((k - 9) / 9) % 2) == 0);
            et = (k == 9 || k == 27);
            checks++;
            if (clk_out[1] !== eo || tick[1] !== et) begin errors++;
                $display("FAIL hp8 k=%0d got out=%b tick=%b exp out=%b tick=%b",
                         k, clk_out[1], tick[1], eo, et); end
        end
    endtask

    task automatic test_shadow();
        wr(3'd2, 1'b0, 32'd5);
        pulse_sync();
        for (int k = 1; k <= 18; k++) begin
            int n;
            logic eo, et;
            step();
            if (k == 3) cfg_we = 1'b0;
            n  = int'(k >= 6) + int'(k >= 10) + int'(k >= 14) + int'(k >= 18);
            eo = (n % 2) == 1;
            et = (k == 6 || k == 14);
            checks++;
            if (clk_out[2] !== eo || tick[2] !== et) begin errors++;
                $display("FAIL shadow k=%0d got out=%b tick=%b exp out=%b tick=%b",
                         k, clk_out[2], tick[2], eo, et); end
            if (k == 2) begin
                cfg_ch = 3'd2; cfg_reg = 1'b0; cfg_wdata = 32'd3; cfg_we = 1'b1;
            end
        end
    endtask

    task automatic test_enable();
        wr(3'd0, 1'b0, 32'd3);
        pulse_sync();
        for (int k = 1; k <= 22; k++) begin
            logic eo, et;
            step();
            eo = (k < 4) ? 1'b0 : (k < 18) ? 1'b1 : (k < 22) ? 1'b0 : 1'b1;
            et = (k == 4 || k == 22);
            checks++;
            if (clk_out[0] !== eo || tick[0] !== et) begin errors++;
                $display("FAIL enable k=%0d got out=%b tick=%b exp out=%b tick=%b",
                         k, clk_out[0], tick[0], eo, et); end
            if (k == 5)  en[0] = 1'b0;
            if (k == 15) en[0] = 1'b1;
        end
    endtask

    task automatic test_same_cycle();
        cfg_ch = 3'd3; cfg_reg = 1'b0; cfg_wdata = 32'd2; cfg_we = 1'b1; sync = 1'b1;
        step();
        cfg_we = 1'b0; sync = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic eo, et;
            step();
            if (k == 3) cfg_we = 1'b0;
            eo = (k == 3 || k == 5);
            et = (k == 3 || k == 5);
            checks++;
            if (clk_out[3] !== eo || tick[3] !== et) begin errors++;
                $display("FAIL same_cycle k=%0d got out=%b tick=%b exp out=%b tick=%b",
                         k, clk_out[3], tick[3], eo, et); end
            if (k == 2) begin
                cfg_ch = 3'd3; cfg_reg = 1'b0; cfg_wdata = 32'd0; cfg_we = 1'b1;
            end
        end
    endtask

    task automatic test_cfg_bounds();
        logic [31:0] eph;
        wr(3'd5, 1'b0, 32'd9);
        cfg_ch = 3'd5; cfg_reg = 1'b0; #1;
        checks++;
        if (cfg_rdata !== 32'd0) begin errors++;
            $display("FAIL oob_rdata got %0d exp 0", cfg_rdata); end
        cfg_ch = 3'd1; #1;
        checks++;
        if (cfg_rdata !== 32'd8) begin errors++;
            $display("FAIL oob_untouched got %0d exp 8", cfg_rdata); end
        wr(3'd0, 1'b1, 32'd4);
`ifdef CLKDIV_PHASE_EN
        eph = 32'd4;
`else
        eph = 32'd0;
`endif
        cfg_ch = 3'd0; cfg_reg = 1'b1; #1;
        checks++;
        if (cfg_rdata !== eph) begin errors++;
            $display("FAIL ph_rdata got %0d exp %0d", cfg_rdata, eph); end
        cfg_reg = 1'b0; #1;
        checks++;
        if (cfg_rdata !== 32'd3) begin errors++;
            $display("FAIL ph_write_hp got %0d exp 3", cfg_rdata); end
    endtask

`ifdef CLKDIV_PHASE_EN
    task automatic test_phase();
        wr(3'd0, 1'b0, 32'd7);
        wr(3'd0, 1'b1, 32'd0);
        wr(3'd1, 1'b0, 32'd7);
        wr(3'd1, 1'b1, 32'd4);
        cfg_ch = 3'd1; cfg_reg = 1'b1; #1;
        checks++;
        if (cfg_rdata !== 32'd4) begin errors++;
            $display("FAIL phase_rdata got %0d exp 4", cfg_rdata); end
        cfg_reg = 1'b0;
        pulse_sync();
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (tick[1] !== (k == 4) || tick[0] !== (k == 8)) begin errors++;
                $display("FAIL phase k=%0d got tick=%b%b exp %b%b",
                         k, tick[1], tick[0], k == 4, k == 8); end
        end
    endtask
`endif

    task automatic test_async_reset();
        pulse_sync();
        for (int k = 1; k <= 10; k++) step();
        checks++;
        if (clk_out[1] !== 1'b1) begin errors++;
            $display("FAIL pre_rst_ch1 got %b exp 1", clk_out[1]); end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin errors++;
            $display("FAIL async_rst got %h/%h exp 0/0", clk_out, tick); end
        cfg_ch = 3'd1; cfg_reg = 1'b0; #1;
        checks++;
        if (cfg_rdata !== 32'd0) begin errors++;
            $display("FAIL rst_hp got %0d exp 0", cfg_rdata); end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            logic [3:0] e;
            step();
            e = (k == 1) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== e) begin errors++;
                $display("FAIL post_rst k=%0d got %h exp %h", k, clk_out, e); end
        end
        wr(3'd5, 1'b0, 32'd7);
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 3'(c); cfg_reg = 1'b0; #1;
            checks++;
            if (cfg_rdata !== 32'd0) begin errors++;
                $display("FAIL oob_after_rst ch=%0d got %0d exp 0", c, cfg_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_hp8();
        test_shadow();
        test_enable();
        test_same_cycle();
        test_cfg_bounds();
`ifdef CLKDIV_PHASE_EN
        test_phase();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
